sensor_event_conditioner: RTL and testbench

Front-end stage for the BBqM people counter. It takes two raw, asynchronous, active-high photo-beam sensors: entry (`sensor_in`) and exit (`sensor_out`). For each sensor it synchronises the input, debounces it, and detects a confirmed beam-break. It drives the `up`/`down` inputs of the up/down counter FSM directly with single-cycle pulses, and never asserts both in the same cycle.

---
 rtl/sensor_event_conditioner.sv | 103 ++++++++++
 tb/tb_sensor_event_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_event_conditioner.sv
// Two-channel photo-beam front end: synchronise, debounce and turn confirmed
// beam-breaks into mutually exclusive single-cycle up/down pulses.
module sensor_event_conditioner #(
   parameter int DB_COUNT = 10,
   parameter int DB_WIDTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_in,
   input  logic sensor_out,
   output logic up,
   output logic down,
   output logic in_busy,
   output logic out_busy
);

   localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_COUNT - 1);

   logic [1:0] raw;
   logic [1:0] rise_evt;
   logic [1:0] stable_vec;

   // channel 0 is entry, channel 1 is exit
   assign raw = {sensor_out, sensor_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic                s1_reg;
         logic                s2_reg;
         logic                stable_reg;
         logic [DB_WIDTH-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               s1_reg     <= 1'b0;
               s2_reg     <= 1'b0;
               stable_reg <= 1'b0;
               cnt_reg    <= '0;
            end else begin
               s1_reg <= raw[gi];
               s2_reg <= s1_reg;
               if (s2_reg == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  stable_reg <= s2_reg;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + DB_WIDTH'(1);
               end
            end
         end

         // Only the accepted 0->1 transition is an event; releases are silent.
         assign rise_evt[gi]   = (s2_reg != stable_reg) && (cnt_reg == CNT_LAST) && s2_reg;
         assign stable_vec[gi] = stable_reg;
      end
   endgenerate

   logic up_reg, up_next;
   logic down_reg, down_next;
   logic pend_up_reg, pend_up_next;
   logic pend_down_reg, pend_down_next;
   logic cand_up, cand_down;

   // Entry wins a collision; the losing exit is parked and issued next free cycle.
   always_comb begin
      cand_up        = pend_up_reg | rise_evt[0];
      cand_down      = pend_down_reg | rise_evt[1];
      up_next        = 1'b0;
      down_next      = 1'b0;
      pend_up_next   = pend_up_reg;
      pend_down_next = pend_down_reg;
      if (cand_up) begin
         up_next        = 1'b1;
         pend_up_next   = 1'b0;
         pend_down_next = cand_down;
      end else if (cand_down) begin
         down_next      = 1'b1;
         pend_down_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         up_reg        <= 1'b0;
         down_reg      <= 1'b0;
         pend_up_reg   <= 1'b0;
         pend_down_reg <= 1'b0;
      end else begin
         up_reg        <= up_next;
         down_reg      <= down_next;
         pend_up_reg   <= pend_up_next;
         pend_down_reg <= pend_down_next;
      end
   end

   assign up       = up_reg;
   assign down     = down_reg;
   assign in_busy  = stable_vec[0];
   assign out_busy = stable_vec[1];

endmodule

// File: tb/tb_sensor_event_conditioner.sv
// Directed table-driven bench for sensor_event_conditioner with DB_COUNT = 4;
// expected outputs per cycle are hand-computed (pulse/busy change 5 edges after input change).
module tb_sensor_event_conditioner;

   localparam int DB_COUNT = 4;
   localparam int DB_WIDTH = 4;

   logic clk = 1'b0;
   logic reset;
   logic sensor_in;
   logic sensor_out;
   logic up;
   logic down;
   logic in_busy;
   logic out_busy;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic rst;
      logic si;
      logic so;
      logic eup;
      logic edn;
      logic eib;
      logic eob;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   sensor_event_conditioner #(
      .DB_COUNT(DB_COUNT),
      .DB_WIDTH(DB_WIDTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sensor_in (sensor_in),
      .sensor_out(sensor_out),
      .up        (up),
      .down      (down),
      .in_busy   (in_busy),
      .out_busy  (out_busy)
   );

   task automatic add(input int n, input logic rst, input logic si, input logic so,
                      input logic eup, input logic edn, input logic eib, input logic eob);
      vec_t v;
      v.rst = rst;
      v.si  = si;
      v.so  = so;
      v.eup = eup;
      v.edn = edn;
      v.eib = eib;
      v.eob = eob;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Inputs change before the edge; outputs are sampled 1 time unit after it.
   task automatic drive(input logic rst, input logic si, input logic so);
      reset      = rst;
      sensor_in  = si;
      sensor_out = so;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ups;
      int downs;
      int pcount;
      logic si;
      logic so;

      reset      = 1'b1;
      sensor_in  = 1'b0;
      sensor_out = 1'b0;

      //   n   rst si so  up dn ib ob
      // reset state
      add(2,  1, 0, 0,  0, 0, 0, 0);
      // entry held 20 cycles: one up pulse 5 edges after sampling
      add(5,  0, 1, 0,  0, 0, 0, 0);
      add(1,  0, 1, 0,  1, 0, 1, 0);
      add(14, 0, 1, 0,  0, 0, 1, 0);
      // entry release: busy drops after 5 edges, no pulse
      add(5,  0, 0, 0,  0, 0, 1, 0);
      add(5,  0, 0, 0,  0, 0, 0, 0);
      // exit glitch of 3 cycles: rejected
      add(3,  0, 0, 1,  0, 0, 0, 0);
      add(10, 0, 0, 0,  0, 0, 0, 0);
      // exit held exactly 4 cycles: accepted
      add(4,  0, 0, 1,  0, 0, 0, 0);
      add(1,  0, 0, 0,  0, 0, 0, 0);
      add(1,  0, 0, 0,  0, 1, 0, 1);
      add(3,  0, 0, 0,  0, 0, 0, 1);
      add(7,  0, 0, 0,  0, 0, 0, 0);
      // both on the same cycle: up then deferred down
      add(5,  0, 1, 1,  0, 0, 0, 0);
      add(1,  0, 1, 1,  1, 0, 1, 1);
      add(1,  0, 1, 1,  0, 1, 1, 1);
      add(3,  0, 1, 1,  0, 0, 1, 1);
      add(5,  0, 0, 0,  0, 0, 1, 1);
      add(5,  0, 0, 0,  0, 0, 0, 0);
      // exit one cycle after entry: consecutive pulses, no deferral
      add(1,  0, 1, 0,  0, 0, 0, 0);
      add(4,  0, 1, 1,  0, 0, 0, 0);
      add(1,  0, 1, 1,  1, 0, 1, 0);
      add(1,  0, 1, 1,  0, 1, 1, 1);
      add(3,  0, 1, 1,  0, 0, 1, 1);
      add(5,  0, 0, 0,  0, 0, 1, 1);
      add(5,  0, 0, 0,  0, 0, 0, 0);
      // reset while down is pending: discarded, then both re-detected
      add(5,  0, 1, 1,  0, 0, 0, 0);
      add(1,  0, 1, 1,  1, 0, 1, 1);
      add(1,  1, 1, 1,  0, 0, 0, 0);
      add(5,  0, 1, 1,  0, 0, 0, 0);
      add(1,  0, 1, 1,  1, 0, 1, 1);
      add(1,  0, 1, 1,  0, 1, 1, 1);
      add(3,  0, 1, 1,  0, 0, 1, 1);
      add(5,  0, 0, 0,  0, 0, 1, 1);
      add(5,  0, 0, 0,  0, 0, 0, 0);
      // entry held across reset release: exactly one pulse afterwards
      add(3,  0, 1, 0,  0, 0, 0, 0);
      add(1,  1, 1, 0,  0, 0, 0, 0);
      add(5,  0, 1, 0,  0, 0, 0, 0);
      add(1,  0, 1, 0,  1, 0, 1, 0);
      add(12, 0, 1, 0,  0, 0, 1, 0);
      add(5,  0, 0, 0,  0, 0, 1, 0);
      add(5,  0, 0, 0,  0, 0, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].si, tbl[i].so);
         $display("step %0d rst=%b in=%b out=%b -> up=%b down=%b in_busy=%b out_busy=%b",
                  i, tbl[i].rst, tbl[i].si, tbl[i].so, up, down, in_busy, out_busy);
         check("up", i, up, tbl[i].eup);
         check("down", i, down, tbl[i].edn);
         check("in_busy", i, in_busy, tbl[i].eib);
         check("out_busy", i, out_busy, tbl[i].eob);
      end

      // Three entry cycles (8 high / 8 low) interleaved with two exit cycles.
      ups    = 0;
      downs  = 0;
      pcount = 0;
      for (int t = 0; t < 60; t++) begin
         si = (t < 48) && ((t % 16) < 8);
         so = (t >= 3) && (t < 35) && (((t - 3) % 16) < 8);
         drive(1'b0, si, so);
         if (up) begin
            ups++;
            pcount++;
         end
         if (down) begin
            downs++;
            pcount--;
         end
         check("up_and_down", 1000 + t, up & down, 1'b0);
      end
      $display("sequence: up pulses=%0d down pulses=%0d pcount=%0d", ups, downs, pcount);
      check_int("up_count", ups, 3);
      check_int("down_count", downs, 2);
      check_int("pcount", pcount, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
